dmi_reg_target: RTL and testbench

- Synthesizable DMI target stage directly downstream of the simulation DTM.
- Consumes debug_req_* transactions and returns debug_resp_* responses.
- Backs a small word-addressed register file plus one exit register; simulation benches use it to close the DTM loop without a full debug module.
- Single outstanding request; response latency set by parameter.

---
 rtl/dmi_reg_target.sv | 120 ++++++++++++
 tb/tb_dmi_reg_target.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_reg_target.sv
// DMI target stage: answers DTM debug requests from a scratch register file plus
// an exit register, one transaction at a time with a fixed response latency.
module dmi_reg_target #(
    parameter int         NREGS        = 16,
    parameter int         RESP_LATENCY = 2,
    parameter logic [6:0] EXIT_ADDR    = 7'h7F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        debug_req_valid,
    output logic        debug_req_ready,
    input  logic [6:0]  debug_req_bits_addr,
    input  logic [1:0]  debug_req_bits_op,
    input  logic [31:0] debug_req_bits_data,
    output logic        debug_resp_valid,
    input  logic        debug_resp_ready,
    output logic [1:0]  debug_resp_bits_resp,
    output logic [31:0] debug_resp_bits_data,
    output logic [31:0] exit
);

    localparam int         IDX_W   = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [6:0] NREGS_A = 7'(NREGS);
    localparam logic [3:0] LATENCY = 4'(RESP_LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [31:0]       regs_q [NREGS];
    logic [31:0]       exit_q;
    logic [1:0]        resp_q, dec_resp;
    logic [31:0]       resp_data_q, dec_data;
    logic              accept, is_reg, is_exit, reg_we, exit_we;
    logic [IDX_W-1:0]  idx;

    assign debug_req_ready = (state_q == IDLE) && !reset;
    assign accept          = debug_req_valid && debug_req_ready;
    assign is_reg          = debug_req_bits_addr < NREGS_A;
    assign is_exit         = debug_req_bits_addr == EXIT_ADDR;
    assign idx             = debug_req_bits_addr[IDX_W-1:0];
    assign reg_we          = accept && (debug_req_bits_op == 2'd2) && is_reg;
    assign exit_we         = accept && (debug_req_bits_op == 2'd2) && is_exit;

    // Response decode; reads sample the register contents as of the accept edge.
    always_comb begin
        dec_resp = 2'd0;
        dec_data = '0;
        case (debug_req_bits_op)
            2'd0: ;
            2'd1: begin
                if (is_reg)       dec_data = regs_q[idx];
                else if (is_exit) dec_data = exit_q;
                else              dec_resp = 2'd2;
            end
            2'd2: begin
                if (!(is_reg || is_exit)) dec_resp = 2'd2;
            end
            default: dec_resp = 2'd2;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY != 4'd0) begin
                        state_d    = WAIT;
                        wait_cnt_d = LATENCY;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q == 4'd1) state_d = RESP;
            end
            RESP: begin
                if (debug_resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            resp_q      <= '0;
            resp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (accept) begin
                resp_q      <= dec_resp;
                resp_data_q <= dec_data;
            end
        end
    end

    // Clearing on reset also discards a write committed by a dropped transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            exit_q <= '0;
        end else begin
            if (reg_we)  regs_q[idx] <= debug_req_bits_data;
            if (exit_we) exit_q      <= debug_req_bits_data;
        end
    end

    assign debug_resp_valid     = (state_q == RESP);
    assign debug_resp_bits_resp = resp_q;
    assign debug_resp_bits_data = resp_data_q;
    assign exit                 = exit_q;

endmodule

// File: tb/tb_dmi_reg_target.sv
// Bench for dmi_reg_target: a transaction-level model checked every cycle on the
// default-latency instance, plus directed back-to-back traffic on a zero-latency one.
module tb_dmi_reg_target;

    localparam int         NREGS_TB = 16;
    localparam int         LAT_TB   = 2;
    localparam logic [6:0] EXIT_TB  = 7'h7F;

    logic        clk = 1'b0;
    logic        reset;
    logic        debug_req_valid, debug_req_ready;
    logic [6:0]  debug_req_bits_addr;
    logic [1:0]  debug_req_bits_op;
    logic [31:0] debug_req_bits_data;
    logic        debug_resp_valid, debug_resp_ready;
    logic [1:0]  debug_resp_bits_resp;
    logic [31:0] debug_resp_bits_data;
    logic [31:0] exit;

    logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
    logic [6:0]  b_req_addr;
    logic [1:0]  b_req_op, b_resp_resp;
    logic [31:0] b_req_data, b_resp_data, b_exit;

    int checks = 0;
    int errors = 0;
    logic check_en = 1'b0;

    always #5 clk = ~clk;

    dmi_reg_target #(.NREGS(NREGS_TB), .RESP_LATENCY(LAT_TB), .EXIT_ADDR(EXIT_TB)) dut (
        .clk(clk), .reset(reset),
        .debug_req_valid(debug_req_valid), .debug_req_ready(debug_req_ready),
        .debug_req_bits_addr(debug_req_bits_addr), .debug_req_bits_op(debug_req_bits_op),
        .debug_req_bits_data(debug_req_bits_data),
        .debug_resp_valid(debug_resp_valid), .debug_resp_ready(debug_resp_ready),
        .debug_resp_bits_resp(debug_resp_bits_resp), .debug_resp_bits_data(debug_resp_bits_data),
        .exit(exit)
    );

    dmi_reg_target #(.NREGS(NREGS_TB), .RESP_LATENCY(0), .EXIT_ADDR(EXIT_TB)) dut_lat0 (
        .clk(clk), .reset(reset),
        .debug_req_valid(b_req_valid), .debug_req_ready(b_req_ready),
        .debug_req_bits_addr(b_req_addr), .debug_req_bits_op(b_req_op),
        .debug_req_bits_data(b_req_data),
        .debug_resp_valid(b_resp_valid), .debug_resp_ready(b_resp_ready),
        .debug_resp_bits_resp(b_resp_resp), .debug_resp_bits_data(b_resp_data),
        .exit(b_exit)
    );

    // Transaction model: busy flag plus edges remaining until the response shows.
    logic        m_busy = 1'b0;
    int          m_rem  = 0;
    logic [1:0]  m_resp = '0;
    logic [31:0] m_data = '0;
    logic [31:0] m_exit = '0;
    logic [31:0] m_regs [NREGS_TB];

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_rem  <= 0;
            m_resp <= '0;
            m_data <= '0;
            m_exit <= '0;
            for (int i = 0; i < NREGS_TB; i++) m_regs[i] <= '0;
        end else if (m_busy) begin
            if (m_rem > 0) m_rem <= m_rem - 1;
            else if (debug_resp_ready) m_busy <= 1'b0;
        end else if (debug_req_valid) begin
            m_resp <= 2'd0;
            m_data <= 32'd0;
            if (debug_req_bits_op == 2'd3) begin
                m_resp <= 2'd2;
            end else if (debug_req_bits_op != 2'd0) begin
                if (int'(debug_req_bits_addr) < NREGS_TB) begin
                    if (debug_req_bits_op == 2'd1) m_data <= m_regs[debug_req_bits_addr[3:0]];
                    else m_regs[debug_req_bits_addr[3:0]] <= debug_req_bits_data;
                end else if (debug_req_bits_addr == EXIT_TB) begin
                    if (debug_req_bits_op == 2'd1) m_data <= m_exit;
                    else m_exit <= debug_req_bits_data;
                end else begin
                    m_resp <= 2'd2;
                end
            end
            m_busy <= 1'b1;
            m_rem  <= LAT_TB;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (check_en) begin
            checkOutput("cyc_req_ready", 32'(debug_req_ready), 32'(!m_busy && !reset));
            checkOutput("cyc_resp_valid", 32'(debug_resp_valid), 32'(m_busy && m_rem == 0));
            checkOutput("cyc_exit", exit, m_exit);
            if (m_busy && m_rem == 0) begin
                checkOutput("cyc_resp", 32'(debug_resp_bits_resp), 32'(m_resp));
                checkOutput("cyc_data", debug_resp_bits_data, m_data);
            end
        end
    end

    // Runs one transaction from a negedge with the target idle; returns on a negedge.
    task automatic applyStimulus(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                                 input int hold, input logic [1:0] exp_resp, input logic [31:0] exp_data,
                                 input int exp_lat);
        int n;
        int lat;
        debug_req_valid     = 1'b1;
        debug_req_bits_op   = op;
        debug_req_bits_addr = addr;
        debug_req_bits_data = data;
        n = 0;
        while (!debug_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_before_accept", 32'(debug_req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        debug_req_bits_op   = 2'd2;
        debug_req_bits_addr = 7'd0;
        debug_req_bits_data = 32'hBAD0BAD0;
        lat = 1;
        while (!debug_resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("resp_valid_seen", 32'(debug_resp_valid), 32'd1);
        checkOutput("latency", 32'(lat), 32'(exp_lat));
        checkOutput("resp_code", 32'(debug_resp_bits_resp), 32'(exp_resp));
        checkOutput("resp_data", debug_resp_bits_data, exp_data);
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            checkOutput("hold_req_ready", 32'(debug_req_ready), 32'd0);
            checkOutput("hold_resp_valid", 32'(debug_resp_valid), 32'd1);
            checkOutput("hold_resp_code", 32'(debug_resp_bits_resp), 32'(exp_resp));
            checkOutput("hold_resp_data", debug_resp_bits_data, exp_data);
        end
        debug_req_valid  = 1'b0;
        debug_resp_ready = 1'b1;
        @(negedge clk);
        debug_resp_ready = 1'b0;
        checkOutput("ready_after_handshake", 32'(debug_req_ready), 32'd1);
        checkOutput("valid_after_handshake", 32'(debug_resp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        debug_req_valid = 1'b0; debug_req_bits_op = '0; debug_req_bits_addr = '0; debug_req_bits_data = '0;
        debug_resp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_op = '0; b_req_addr = '0; b_req_data = '0; b_resp_ready = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_req_ready", 32'(debug_req_ready), 32'd0);
        checkOutput("rst_resp_valid", 32'(debug_resp_valid), 32'd0);
        checkOutput("rst_exit", exit, 32'd0);
        checkOutput("rst_resp", 32'(debug_resp_bits_resp), 32'd0);
        checkOutput("rst_data", debug_resp_bits_data, 32'd0);
        check_en = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_req_ready", 32'(debug_req_ready), 32'd1);

        applyStimulus(2'd2, 7'd3, 32'hDEADBEEF, 0, 2'd0, 32'd0, 3);
        applyStimulus(2'd1, 7'd3, 32'd0, 10, 2'd0, 32'hDEADBEEF, 3);
        applyStimulus(2'd1, 7'h20, 32'd0, 0, 2'd2, 32'd0, 3);
        applyStimulus(2'd2, 7'd0, 32'h12345678, 0, 2'd0, 32'd0, 3);
        applyStimulus(2'd3, 7'd0, 32'h0000FFFF, 0, 2'd2, 32'd0, 3);
        applyStimulus(2'd1, 7'd0, 32'd0, 0, 2'd0, 32'h12345678, 3);
        applyStimulus(2'd0, 7'd3, 32'h11111111, 0, 2'd0, 32'd0, 3);
        applyStimulus(2'd2, 7'd15, 32'hCAFEF00D, 0, 2'd0, 32'd0, 3);
        applyStimulus(2'd1, 7'd15, 32'd0, 0, 2'd0, 32'hCAFEF00D, 3);
        applyStimulus(2'd2, 7'd16, 32'h0BADC0DE, 0, 2'd2, 32'd0, 3);
        applyStimulus(2'd2, EXIT_TB, 32'h1, 0, 2'd0, 32'd0, 3);
        checkOutput("exit_after_write", exit, 32'd1);
        applyStimulus(2'd1, EXIT_TB, 32'd0, 0, 2'd0, 32'd1, 3);

        // Reset lands while the write to addr 5 is still waiting for its response.
        debug_req_valid     = 1'b1;
        debug_req_bits_op   = 2'd2;
        debug_req_bits_addr = 7'd5;
        debug_req_bits_data = 32'h55555555;
        @(posedge clk);
        @(negedge clk);
        debug_req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("no_resp_after_reset", 32'(debug_resp_valid), 32'd0);
        end
        checkOutput("exit_after_reset", exit, 32'd0);
        applyStimulus(2'd1, 7'd5, 32'd0, 0, 2'd0, 32'd0, 3);
        applyStimulus(2'd1, 7'd3, 32'd0, 0, 2'd0, 32'd0, 3);

        // Zero-latency instance: valid and ready tied high, one transaction per 2 cycles.
        b_req_valid  = 1'b1;
        b_resp_ready = 1'b1;
        for (int k = 0; k < 32; k++) begin
            int j;
            checkOutput("lat0_resp_valid", 32'(b_resp_valid), 32'(k % 2));
            checkOutput("lat0_req_ready", 32'(b_req_ready), 32'((k + 1) % 2));
            if (k % 2 == 0) begin
                j = k / 2;
                if (j < 8) begin
                    b_req_op   = 2'd2;
                    b_req_addr = 7'(j);
                    b_req_data = 32'h1000 + 32'(j) * 32'h11;
                end else begin
                    b_req_op   = 2'd1;
                    b_req_addr = 7'(j - 8);
                    b_req_data = 32'hFFFFFFFF;
                end
            end else begin
                j = (k - 1) / 2;
                checkOutput("lat0_resp", 32'(b_resp_resp), 32'd0);
                checkOutput("lat0_data", b_resp_data, (j < 8) ? 32'd0 : 32'h1000 + 32'(j - 8) * 32'h11);
                if (j == 15) checkOutput("lat0_last_read", b_resp_data, 32'h1077);
            end
            @(negedge clk);
        end
        b_req_valid  = 1'b0;
        b_resp_ready = 1'b0;
        checkOutput("lat0_exit", b_exit, 32'd0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
